// File: rtl/inst_pkg.sv
// -----------------------------------------------------------------------------
// inst_pkg
// Shared definitions for the instruction dispatcher: instruction word geometry,
// the bit positions of every ILC / W2C config field inside the instruction
// word, and the dispatcher state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_pkg;

    // Instruction word geometry
    localparam int INST_LEN = 220;
    localparam int LAST_BIT = 219;

    // ILC config slice, inst[59:0]
    localparam int ILC_CFG_W             = 60;
    localparam int ILC_ST_ADDR_LSB       = 0;
    localparam int ILC_ST_ADDR_MSB       = 35;
    localparam int ILC_ISPAD_BIT         = 36;
    localparam int ILC_LINELEN_LSB       = 37;
    localparam int ILC_LINELEN_MSB       = 45;
    localparam int ILC_BSR_ISZERO_LSB    = 46;
    localparam int ILC_BSR_ISZERO_MSB    = 49;
    localparam int ILC_BSR_BUFFERMUX_LSB = 50;
    localparam int ILC_BSR_BUFFERMUX_MSB = 57;
    localparam int ILC_FROMFIFO_BIT      = 58;
    localparam int ILC_TOFIFO_BIT        = 59;

    // W2C config slice, inst[136:60]
    localparam int W2C_CFG_W             = 77;
    localparam int W2C_IS_BACK_BIT       = 60;
    localparam int W2C_BIAS_SHIFT_LSB    = 132;
    localparam int W2C_BIAS_SHIFT_MSB    = 136;

    // Dispatcher states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/done_tracker.sv
// -----------------------------------------------------------------------------
// done_tracker
// Remembers which of the two downstream units (ILC, W2C) has reported
// completion for the instruction currently in flight, and flags the cycle on
// which both have finished.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   issue     in   dispatcher is in its ISSUE cycle
//   waiting   in   dispatcher is in WAIT
//   w2c_skip  in   current instruction does not use W2C (counts as already done)
//   ilc_done  in   ILC completion pulse
//   w2c_done  in   W2C completion pulse
//   all_done  out  both units finished; asserted only while waiting
// -----------------------------------------------------------------------------
module done_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic waiting,
    input  logic w2c_skip,
    input  logic ilc_done,
    input  logic w2c_done,
    output logic all_done
);

    logic ilc_seen;
    logic w2c_seen;
    logic armed;

    // A unit may finish in the very cycle it is started, so pulses are
    // captured from ISSUE onwards; anything arriving in IDLE/HALT is dropped.
    assign armed = issue | waiting;

    // Current pulses are OR'd in so completion costs no extra cycle.
    assign all_done = waiting & (ilc_seen | ilc_done) & (w2c_seen | w2c_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ilc_seen <= 1'b0;
            w2c_seen <= 1'b0;
        end else if (all_done) begin
            ilc_seen <= 1'b0;
            w2c_seen <= 1'b0;
        end else if (armed) begin
            ilc_seen <= ilc_seen | ilc_done;
            w2c_seen <= w2c_seen | w2c_done | (issue & w2c_skip);
        end
    end

endmodule

// File: rtl/inst_dispatch.sv
// -----------------------------------------------------------------------------
// inst_dispatch
// Pops one instruction at a time from a show-ahead instruction FIFO, slices it
// into the ILC and W2C configuration words, starts both units and waits for
// both to finish before fetching the next one. An instruction with the last
// marker set parks the block in HALT until reset.
//
// Optional build macro: INST_DISPATCH_PERF_EN adds the stall_cyc / wait_cyc
// saturating performance counters and their output ports.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   run         in   fetch enable (level)
//   instruct    in   FIFO head word, valid when inst_empty=0
//   inst_empty  in   FIFO empty
//   inst_req    out  FIFO pop strobe (combinational)
//   ilc_cfg     out  ILC config, instruction bits [59:0]
//   w2c_cfg     out  W2C config, instruction bits [136:60]
//   ilc_start   out  one-cycle ILC start pulse
//   w2c_start   out  one-cycle W2C start pulse (only if is_w2c_back)
//   ilc_done    in   ILC completion pulse
//   w2c_done    in   W2C completion pulse
//   busy        out  instruction in flight
//   halted      out  last instruction completed
//   inst_cnt    out  instructions issued (wraps)
//   stall_cyc   out  [perf] IDLE cycles starved by an empty FIFO (saturating)
//   wait_cyc    out  [perf] cycles spent waiting for completion (saturating)
// -----------------------------------------------------------------------------
module inst_dispatch #(
    parameter int INST_LEN = inst_pkg::INST_LEN,
    parameter int LAST_BIT = inst_pkg::LAST_BIT,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [INST_LEN-1:0] instruct,
    input  logic                inst_empty,
    output logic                inst_req,
    output logic [59:0]         ilc_cfg,
    output logic [76:0]         w2c_cfg,
    output logic                ilc_start,
    output logic                w2c_start,
    input  logic                ilc_done,
    input  logic                w2c_done,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    inst_cnt
`ifdef INST_DISPATCH_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cyc,
    output logic [CNT_W-1:0]    wait_cyc
`endif
);

    import inst_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_nxt;
    logic [INST_LEN-1:0]   inst_q;
    logic                  all_done;
    logic                  unused_inst_bits;

    // Only the W2C-enable and last-marker bits of the held word steer control;
    // the rest is kept as a full copy of the fetched instruction.
    assign unused_inst_bits = ^inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational strobes. The pop and the ISSUE
    // transition share one edge, so a fetch pops exactly once.
    always_comb begin
        state_nxt = state;
        inst_req  = 1'b0;
        ilc_start = 1'b0;
        w2c_start = 1'b0;
        case (state)
            IDLE: begin
                if (run && !inst_empty) begin
                    inst_req  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ilc_start = 1'b1;
                w2c_start = inst_q[W2C_IS_BACK_BIT];
                state_nxt = WAIT;
            end
            WAIT: begin
                if (all_done) begin
                    state_nxt = inst_q[LAST_BIT] ? HALT : IDLE;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = (state == ISSUE) || (state == WAIT);
    assign halted = (state == HALT);

    // Config words are taken straight from the FIFO head on the fetch edge so
    // they are already valid while the start pulses are out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= '0;
            ilc_cfg <= '0;
            w2c_cfg <= '0;
        end else if (inst_req) begin
            inst_q  <= instruct;
            ilc_cfg <= {instruct[ILC_TOFIFO_BIT],
                        instruct[ILC_FROMFIFO_BIT],
                        instruct[ILC_BSR_BUFFERMUX_MSB:ILC_BSR_BUFFERMUX_LSB],
                        instruct[ILC_BSR_ISZERO_MSB:ILC_BSR_ISZERO_LSB],
                        instruct[ILC_LINELEN_MSB:ILC_LINELEN_LSB],
                        instruct[ILC_ISPAD_BIT],
                        instruct[ILC_ST_ADDR_MSB:ILC_ST_ADDR_LSB]};
            w2c_cfg <= {instruct[W2C_BIAS_SHIFT_MSB:W2C_BIAS_SHIFT_LSB],
                        instruct[W2C_BIAS_SHIFT_LSB-1:W2C_IS_BACK_BIT+1],
                        instruct[W2C_IS_BACK_BIT]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_cnt <= '0;
        end else if (state == ISSUE) begin
            inst_cnt <= inst_cnt + CNT_ONE;
        end
    end

    done_tracker u_done_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (state == ISSUE),
        .waiting  (state == WAIT),
        .w2c_skip (!inst_q[W2C_IS_BACK_BIT]),
        .ilc_done (ilc_done),
        .w2c_done (w2c_done),
        .all_done (all_done)
    );

`ifdef INST_DISPATCH_PERF_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc <= '0;
            wait_cyc  <= '0;
        end else begin
            if ((state == IDLE) && run && inst_empty && (stall_cyc != '1)) begin
                stall_cyc <= stall_cyc + CNT_ONE;
            end
            if ((state == WAIT) && (wait_cyc != '1)) begin
                wait_cyc <= wait_cyc + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_dispatch.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatch
// Self-checking bench for inst_dispatch. A queue stands in for the instruction
// FIFO; a transaction-level model tracks the instruction in flight by its
// fetch cycle and which completions have been observed, and predicts every
// output each cycle. Directed scenarios are followed by a randomized run.
// Define INST_DISPATCH_PERF_EN to also check the perf counters.
// -----------------------------------------------------------------------------
module tb_inst_dispatch;

    import inst_pkg::*;

    localparam int CNT_W     = 32;
    localparam int BACK_BIT  = 60;
    localparam int END_BIT   = 219;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run;
    logic [INST_LEN-1:0] instruct;
    logic                inst_empty;
    logic                inst_req;
    logic [59:0]         ilc_cfg;
    logic [76:0]         w2c_cfg;
    logic                ilc_start;
    logic                w2c_start;
    logic                ilc_done;
    logic                w2c_done;
    logic                busy;
    logic                halted;
    logic [CNT_W-1:0]    inst_cnt;
`ifdef INST_DISPATCH_PERF_EN
    logic [CNT_W-1:0]    stall_cyc;
    logic [CNT_W-1:0]    wait_cyc;
`endif

    always #5 clk = ~clk;

    inst_dispatch #(
        .INST_LEN (INST_LEN),
        .LAST_BIT (LAST_BIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .instruct   (instruct),
        .inst_empty (inst_empty),
        .inst_req   (inst_req),
        .ilc_cfg    (ilc_cfg),
        .w2c_cfg    (w2c_cfg),
        .ilc_start  (ilc_start),
        .w2c_start  (w2c_start),
        .ilc_done   (ilc_done),
        .w2c_done   (w2c_done),
        .busy       (busy),
        .halted     (halted),
        .inst_cnt   (inst_cnt)
`ifdef INST_DISPATCH_PERF_EN
        ,
        .stall_cyc  (stall_cyc),
        .wait_cyc   (wait_cyc)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [INST_LEN-1:0] fifo [$];

    // Reference model: one instruction in flight at most
    bit                  m_active;
    bit                  m_halted;
    bit                  m_ilc_ok;
    bit                  m_w2c_ok;
    int                  m_fetch_cyc;
    logic [INST_LEN-1:0] m_cur;
    logic [CNT_W-1:0]    m_cnt;
    logic [CNT_W-1:0]    m_stall;
    logic [CNT_W-1:0]    m_wait;

    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, actual, expected);
        end
    endtask

    function automatic logic [INST_LEN-1:0] randWord(input bit last);
        logic [223:0]        raw;
        logic [INST_LEN-1:0] w;
        for (int i = 0; i < 7; i++) begin
            raw[i*32 +: 32] = $urandom();
        end
        w          = raw[INST_LEN-1:0];
        w[END_BIT] = last;
        return w;
    endfunction

    task automatic resetModel();
        m_active    = 1'b0;
        m_halted    = 1'b0;
        m_ilc_ok    = 1'b0;
        m_w2c_ok    = 1'b0;
        m_fetch_cyc = 0;
        m_cur       = '0;
        m_cnt       = '0;
        m_stall     = '0;
        m_wait      = '0;
    endtask

    task automatic checkAll(input bit exp_req, input bit exp_start);
        checkOutput("inst_req",  inst_req,  exp_req);
        checkOutput("ilc_start", ilc_start, exp_start);
        checkOutput("w2c_start", w2c_start, exp_start && m_cur[BACK_BIT]);
        checkOutput("busy",      busy,      m_active);
        checkOutput("halted",    halted,    m_halted);
        checkOutput("inst_cnt",  inst_cnt,  m_cnt);
        checkOutput("ilc_cfg",   ilc_cfg,   m_cur[59:0]);
        checkOutput("w2c_cfg",   w2c_cfg,   m_cur[136:60]);
`ifdef INST_DISPATCH_PERF_EN
        checkOutput("stall_cyc", stall_cyc, m_stall);
        checkOutput("wait_cyc",  wait_cyc,  m_wait);
`endif
    endtask

    // One clock cycle: drive at the falling edge, check just after, then
    // advance the model and the FIFO across the following rising edge.
    task automatic applyStimulus(input bit run_v, input bit ilc_v, input bit w2c_v);
        bit exp_req;
        bit exp_start;
        @(negedge clk);
        run        = run_v;
        ilc_done   = ilc_v;
        w2c_done   = w2c_v;
        inst_empty = (fifo.size() == 0);
        instruct   = inst_empty ? randWord($urandom_range(0, 1) == 1) : fifo[0];
        #1;
        exp_req   = !m_active && !m_halted && run_v && (fifo.size() != 0);
        exp_start = m_active && (cyc == m_fetch_cyc + 1);
        checkAll(exp_req, exp_start);

        if (!m_active && !m_halted && run_v && (fifo.size() == 0) && (m_stall != '1)) m_stall++;
        if (m_active && (cyc >= m_fetch_cyc + 2) && (m_wait != '1)) m_wait++;

        if (m_active) begin
            m_ilc_ok = m_ilc_ok | ilc_v;
            m_w2c_ok = m_w2c_ok | w2c_v;
            if (cyc == m_fetch_cyc + 1) begin
                m_cnt++;
            end else if (m_ilc_ok && m_w2c_ok) begin
                m_active = 1'b0;
                m_ilc_ok = 1'b0;
                m_w2c_ok = 1'b0;
                if (m_cur[END_BIT]) m_halted = 1'b1;
            end
        end else if (exp_req) begin
            m_active    = 1'b1;
            m_fetch_cyc = cyc;
            m_cur       = fifo[0];
            m_ilc_ok    = 1'b0;
            m_w2c_ok    = !fifo[0][BACK_BIT];
        end

        if (inst_req && (fifo.size() != 0)) void'(fifo.pop_front());
        cyc++;
    endtask

    // Asynchronous reset asserted between clock edges; outputs are checked
    // before any rising edge has passed.
    task automatic doReset();
        @(negedge clk);
        run      = 1'b0;
        ilc_done = 1'b0;
        w2c_done = 1'b0;
        rst_n    = 1'b0;
        #1;
        resetModel();
        checkAll(1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [INST_LEN-1:0] w;
        int                  halt_cycles;

        rst_n      = 1'b0;
        run        = 1'b0;
        ilc_done   = 1'b0;
        w2c_done   = 1'b0;
        instruct   = '0;
        inst_empty = 1'b1;
        resetModel();
        doReset();

        // W2C used; ILC done 3 cycles after the pop, W2C done after 5
        w              = randWord(1'b0);
        w[BACK_BIT]    = 1'b1;
        w[59:0]        = 60'h0ABC123456789AB;
        fifo.push_back(w);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 3, i == 5);

        // W2C unused; a late W2C pulse lands in IDLE and must be ignored
        w           = randWord(1'b0);
        w[BACK_BIT] = 1'b0;
        fifo.push_back(w);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 2, i == 6);

        // Both completions in the same WAIT cycle
        w           = randWord(1'b0);
        w[BACK_BIT] = 1'b1;
        fifo.push_back(w);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 3, i == 3);

        // run held low with a word waiting, then raised
        fifo.push_back(randWord(1'b0));
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)  applyStimulus(1'b1, 1'b1, 1'b1);

        // Three words, last one halts; a fourth must stay in the FIFO
        fifo.push_back(randWord(1'b0));
        fifo.push_back(randWord(1'b0));
        fifo.push_back(randWord(1'b1));
        fifo.push_back(randWord(1'b0));
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("halt_fifo_left", fifo.size(), 1);
        doReset();

        // Randomized traffic with occasional mid-flight resets
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if ((fifo.size() < 4) && ($urandom_range(0, 1) == 1)) begin
                fifo.push_back(randWord($urandom_range(0, 9) == 0));
            end
            applyStimulus($urandom_range(0, 7) != 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0);
            if (m_halted) begin
                halt_cycles++;
                if (halt_cycles >= 4) begin
                    doReset();
                    halt_cycles = 0;
                end
            end else if (m_active && (cyc >= m_fetch_cyc + 2) && ($urandom_range(0, 39) == 0)) begin
                doReset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
